// File: rtl/pg_switch_pkg.sv
// Shared types and defaults for the power-gate switch responder.
// The state encoding is fixed so the PMU can observe it in debug.
package pg_switch_pkg;

  typedef enum logic [2:0] {
    ON        = 3'd0,
    RAMP_DOWN = 3'd1,
    OFF       = 3'd2,
    RAMP_UP   = 3'd3,
    SETTLE    = 3'd4
  } pg_sw_state_e;

  localparam int PG_SW_NUM_SEG_DEF = 4;
  localparam int PG_SW_STEP_DEF    = 8;
  localparam int PG_SW_SETTLE_DEF  = 16;
  localparam int PG_SW_TIMEOUT_DEF = 256;

  // Sizes the shared step/settle/timeout counter for its longest use.
  function automatic int pg_sw_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// Generic multi-flop synchronizer cell for single-bit asynchronous inputs.
// Only compiled when PG_SWITCH_CHAIN_ACK_EN is defined, its sole user here.
`ifdef PG_SWITCH_CHAIN_ACK_EN
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule
`endif

// File: rtl/pg_switch_step_timer.sv
// Reloadable down-counter; tick is high once the loaded count has elapsed.
// The owner reloads it on every step, so ticks come one every load_val+1 cycles.
module pg_switch_step_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/pg_switch_responder.sv
// Sleep_send/sleep_ack responder that staggers NUM_SEG header-switch segments.
// Optional macro PG_SWITCH_CHAIN_ACK_EN: settle on synchronized chain_ack_i with timeout/err_o.
module pg_switch_responder
  import pg_switch_pkg::*;
#(
  parameter int NUM_SEG        = PG_SW_NUM_SEG_DEF,
  parameter int STEP_CYCLES    = PG_SW_STEP_DEF,
  parameter int SETTLE_CYCLES  = PG_SW_SETTLE_DEF,
  parameter int TIMEOUT_CYCLES = PG_SW_TIMEOUT_DEF,
  parameter int RESET_ON       = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             sleep_req_i,
  output logic                             sleep_ack_o,
  output logic [NUM_SEG-1:0]               seg_en_o,
  input  logic                             chain_ack_i,
  output logic                             busy_o,
  output logic                             err_o,
  output logic [$clog2(NUM_SEG+1)-1:0]     seg_cnt_o
);

  localparam int CW = $clog2(NUM_SEG + 1);
  localparam int TW = $clog2(pg_sw_max3(STEP_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [TW-1:0] STEP_LD = TW'(STEP_CYCLES - 1);
`ifdef PG_SWITCH_CHAIN_ACK_EN
  localparam logic [TW-1:0] SETTLE_LD = TW'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
`endif

  localparam pg_sw_state_e       RESET_STATE = (RESET_ON != 0) ? ON : OFF;
  localparam logic [CW-1:0]      RESET_CNT   = (RESET_ON != 0) ? CW'(NUM_SEG) : '0;
  localparam logic [NUM_SEG-1:0] RESET_SEG   = (RESET_ON != 0) ? {NUM_SEG{1'b1}} : '0;
  localparam logic               RESET_ACK   = (RESET_ON == 0);

  pg_sw_state_e       state_q, state_d;
  logic [CW-1:0]      seg_cnt_q, seg_cnt_d;
  logic [NUM_SEG-1:0] seg_en_q, seg_en_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;

  logic               step_down, step_up;
  logic               settle_exit, settle_tmo;
  logic               chain_sync;

  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_tick;

  pg_switch_step_timer #(
    .WIDTH (TW)
  ) u_step_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick)
  );

`ifdef PG_SWITCH_CHAIN_ACK_EN
  logic err_q;

  cdc_sync #(
    .STAGES (2)
  ) u_chain_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (chain_ack_i),
    .q     (chain_sync)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (settle_tmo) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_chain_ack;

  assign unused_chain_ack = chain_ack_i;
  assign chain_sync       = 1'b0;
  assign err_o            = 1'b0;
`endif

  always_ff @(posedge clk_i) begin : state_reg
    if (rst_i) begin
      state_q   <= RESET_STATE;
      seg_cnt_q <= RESET_CNT;
      seg_en_q  <= RESET_SEG;
      ack_q     <= RESET_ACK;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      seg_en_q  <= seg_en_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  // A reversal steps immediately; same-direction steps wait for the timer tick.
  always_comb begin : next_state_comb
    state_d     = state_q;
    step_down   = 1'b0;
    step_up     = 1'b0;
    settle_exit = 1'b0;
    settle_tmo  = 1'b0;
    unique case (state_q)
      ON: begin
        if (sleep_req_i) step_down = 1'b1;
      end
      RAMP_DOWN: begin
        if (!sleep_req_i)  step_up   = 1'b1;
        else if (tmr_tick) step_down = 1'b1;
      end
      OFF: begin
        if (!sleep_req_i) step_up = 1'b1;
      end
      RAMP_UP: begin
        if (sleep_req_i)   step_down = 1'b1;
        else if (tmr_tick) step_up   = 1'b1;
      end
      SETTLE: begin
        if (sleep_req_i) begin
          step_down = 1'b1;
`ifdef PG_SWITCH_CHAIN_ACK_EN
        end else if (chain_sync) begin
          settle_exit = 1'b1;
        end else if (tmr_tick) begin
          settle_tmo = 1'b1;
`else
        end else if (tmr_tick) begin
          settle_exit = 1'b1;
`endif
        end
      end
      default: ;
    endcase

    if (step_down) begin
      state_d = (seg_cnt_q == CW'(1)) ? OFF : RAMP_DOWN;
    end else if (step_up) begin
      state_d = (seg_cnt_q == CW'(NUM_SEG - 1)) ? SETTLE : RAMP_UP;
    end else if (settle_exit || settle_tmo) begin
      state_d = ON;
    end
  end

  // Segments form a thermometer code of the count, so ramps never skip a pattern.
  always_comb begin : output_comb
    seg_cnt_d = seg_cnt_q;
    tmr_load  = 1'b0;
    tmr_val   = STEP_LD;
    if (step_down) begin
      seg_cnt_d = seg_cnt_q - CW'(1);
      tmr_load  = 1'b1;
    end else if (step_up) begin
      seg_cnt_d = seg_cnt_q + CW'(1);
      tmr_load  = 1'b1;
    end
    if ((state_d == SETTLE) && (state_q != SETTLE)) begin
      tmr_val = SETTLE_LD;
    end

    seg_en_d = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      seg_en_d[i] = (i < int'(seg_cnt_d));
    end

    unique case (state_d)
      OFF:     ack_d = 1'b1;
      ON:      ack_d = 1'b0;
      default: ack_d = ack_q;
    endcase

    busy_d = (state_d == RAMP_DOWN) || (state_d == RAMP_UP) || (state_d == SETTLE);
  end

  assign sleep_ack_o = ack_q;
  assign seg_en_o    = seg_en_q;
  assign seg_cnt_o   = seg_cnt_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_pg_switch_responder.sv
// Randomized self-checking bench for pg_switch_responder against a count/timestamp model.
// Works with or without PG_SWITCH_CHAIN_ACK_EN defined.
module tb_pg_switch_responder;

  localparam int NUM_SEG = 4;
  localparam int STEP    = 8;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 256;
  localparam int CW      = $clog2(NUM_SEG + 1);

  logic               clk_i       = 1'b0;
  logic               rst_i       = 1'b1;
  logic               sleep_req_i = 1'b0;
  logic               chain_ack_i = 1'b0;
  logic               sleep_ack_o;
  logic [NUM_SEG-1:0] seg_en_o;
  logic               busy_o;
  logic               err_o;
  logic [CW-1:0]      seg_cnt_o;

  pg_switch_responder #(
    .NUM_SEG        (NUM_SEG),
    .STEP_CYCLES    (STEP),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .RESET_ON       (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sleep_req_i (sleep_req_i),
    .sleep_ack_o (sleep_ack_o),
    .seg_en_o    (seg_en_o),
    .chain_ack_i (chain_ack_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .seg_cnt_o   (seg_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checksDone   = 0;
  int checksPassed = 0;
  int cycleNo      = 0;

  // Model: segments on, when/which way the last step went, settle bookkeeping.
  int mCnt;
  int mLastStep;
  int mSettleStart;
  bit mLastDown;
  bit mAck;
  bit mErr;
  bit mSettling;
`ifdef PG_SWITCH_CHAIN_ACK_EN
  bit mChainD1;
  bit mChainD2;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksDone++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  task automatic modelReset();
    mCnt      = NUM_SEG;
    mLastStep = -100000;
    mLastDown = 1'b0;
    mAck      = 1'b0;
    mErr      = 1'b0;
    mSettling = 1'b0;
`ifdef PG_SWITCH_CHAIN_ACK_EN
    mChainD1  = 1'b0;
    mChainD2  = 1'b0;
`endif
  endtask

  // One clock edge of the reference behaviour given the sampled inputs.
  task automatic modelEdge(input bit req, input bit rst);
    int want;
    bit stepNow;
    if (rst) begin
      modelReset();
      return;
    end
    want    = req ? 0 : NUM_SEG;
    stepNow = (mCnt != want) && ((req != mLastDown) || (cycleNo - mLastStep >= STEP));
    if (stepNow) begin
      mCnt      = req ? mCnt - 1 : mCnt + 1;
      mLastDown = req;
      mLastStep = cycleNo;
      mSettling = 1'b0;
      if (mCnt == 0) mAck = 1'b1;
      if (mCnt == NUM_SEG) begin
        mSettling    = 1'b1;
        mSettleStart = cycleNo;
      end
    end else if (mSettling) begin
`ifdef PG_SWITCH_CHAIN_ACK_EN
      if (mChainD2) begin
        mSettling = 1'b0;
        mAck      = 1'b0;
      end else if (cycleNo - mSettleStart >= TIMEOUT) begin
        mSettling = 1'b0;
        mAck      = 1'b0;
        mErr      = 1'b1;
      end
`else
      if (cycleNo - mSettleStart >= SETTLE) begin
        mSettling = 1'b0;
        mAck      = 1'b0;
      end
`endif
    end
  endtask

  task automatic applyStimulus(input bit req, input bit chain, input bit rst);
    sleep_req_i = req;
    chain_ack_i = chain;
    rst_i       = rst;
    @(posedge clk_i);
    cycleNo++;
    modelEdge(req, rst);
`ifdef PG_SWITCH_CHAIN_ACK_EN
    if (!rst) begin
      mChainD2 = mChainD1;
      mChainD1 = chain;
    end
`endif
    #1;
    checkOutput("seg_en",  seg_en_o,    (1 << mCnt) - 1);
    checkOutput("seg_cnt", seg_cnt_o,   mCnt);
    checkOutput("ack",     sleep_ack_o, mAck);
    checkOutput("busy",    busy_o,      mSettling || (mCnt > 0 && mCnt < NUM_SEG));
    checkOutput("err",     err_o,       mErr);
  endtask

  initial begin
    int startCycle;
    int fullCycle;
    int waitN;
    bit chainVal;
    bit req;
    int len;
    int chainMode;

    modelReset();
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);

    // Power-down from ON: ack rises (NUM_SEG-1)*STEP edges after the first step.
    startCycle = cycleNo + 1;
    waitN = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    while (sleep_ack_o !== 1'b1 && waitN < 100) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitN++;
    end
    checkOutput("ack_rise_latency", cycleNo - startCycle, (NUM_SEG - 1) * STEP);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("off_seg_en", seg_en_o, 0);

    // Power-up: settle time (or timeout with chain_ack held low) after full enable.
    waitN = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    while (seg_cnt_o != NUM_SEG && waitN < 100) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitN++;
    end
    fullCycle = cycleNo;
    checkOutput("full_seg_en", seg_en_o, 4'hF);
    waitN = 0;
    while (sleep_ack_o !== 1'b0 && waitN < 400) begin
`ifdef PG_SWITCH_CHAIN_ACK_EN
      chainVal = 1'b0;
`else
      chainVal = 1'($urandom_range(0, 1));
`endif
      applyStimulus(1'b0, chainVal, 1'b0);
      waitN++;
    end
`ifdef PG_SWITCH_CHAIN_ACK_EN
    checkOutput("timeout_latency", cycleNo - fullCycle, TIMEOUT);
    checkOutput("timeout_err", err_o, 1);
`else
    checkOutput("settle_latency", cycleNo - fullCycle, SETTLE);
`endif
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    // Reversal at two segments: ramp-up resumes from the current count.
    waitN = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    while (seg_cnt_o != 2 && waitN < 100) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitN++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reversal_seg_en", seg_en_o, 4'b0111);
    checkOutput("reversal_ack", sleep_ack_o, 0);

    // Reset while one segment remains mid ramp-down.
    waitN = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    while (seg_cnt_o != 1 && waitN < 100) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitN++;
    end
    checkOutput("pre_reset_cnt", seg_cnt_o, 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("mid_reset_seg_en", seg_en_o, 4'hF);
    checkOutput("mid_reset_busy", busy_o, 0);
    checkOutput("mid_reset_ack", sleep_ack_o, 0);

    // Random request phases, with occasional long holds and reset pulses.
    for (int p = 0; p < 60; p++) begin
      req       = 1'($urandom_range(0, 1));
      len       = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(1, 40);
      chainMode = $urandom_range(0, 2);
      if ($urandom_range(0, 15) == 0) applyStimulus(req, 1'b0, 1'b1);
      for (int c = 0; c < len; c++) begin
        chainVal = (chainMode == 2) ? 1'($urandom_range(0, 1)) : 1'(chainMode);
        applyStimulus(req, chainVal, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule

// File: doc/pg_switch_responder.md
Name: pg_switch_responder

Overview:
- Responder end of the sleep_send/sleep_ack power-gate handshake driven by the PMU's per-domain power-gate FSMs.
- One instance per gated domain (LOGIC, L2, L2_UDMA, L1, UDMA).
- Converts a level sleep request into a staggered enable/disable of NUM_SEG header-switch segments to limit inrush current.
- Confirms each completed transition on sleep_ack_o using four-phase level handshaking.

Parameters:
- NUM_SEG, 4: number of switch segments, 1..16.
- STEP_CYCLES, 8: cycles between consecutive segment transitions, ≥1.
- SETTLE_CYCLES, 16: fixed post-ramp-up settle time, used when chain-ack is compiled out.
- TIMEOUT_CYCLES, 256: maximum wait for chain_ack_i before declaring an error.
- RESET_ON, 1: 1 = domain powered after reset; 0 = domain off after reset.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- sleep_req_i  in  1  1 = power domain off, 0 = power domain on (from the PMU's sleep_send)
- sleep_ack_o  out  1  equals sleep_req_i once the requested state is fully reached
- seg_en_o  out  NUM_SEG  per-segment switch enable, 1 = on
- chain_ack_i  in  1  daisy-chain return from the last switch segment; 1 = all segments conducting
- busy_o  out  1  ramp or settle in progress
- err_o  out  1  sticky: settle timeout occurred
- seg_cnt_o  out  $clog2(NUM_SEG+1)  number of segments currently enabled

Behaviour:
- Interface decision: one clock, clk_i. Reset rst_i is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - RESET_ON=1: state ON, seg_en_o all ones, seg_cnt_o=NUM_SEG, sleep_ack_o=0.
  - RESET_ON=0: state OFF, seg_en_o=0, seg_cnt_o=0, sleep_ack_o=1.
  - In both cases: busy_o=0, err_o=0.
- Reset asserted mid-ramp forces the reset state on the next edge, with no intermediate segment pattern.
- States: ON, RAMP_DOWN, OFF, RAMP_UP, SETTLE.
- ON:
  - sleep_req_i=1 sampled at edge t → RAMP_DOWN.
  - Segment NUM_SEG-1 is cleared at edge t+1, and the step counter loads STEP_CYCLES-1.
- RAMP_DOWN:
  - The step counter decrements each cycle.
  - When it reaches 0, the next-lower segment is cleared and the counter reloads.
  - Segments are cleared highest-first.
  - When seg_cnt_o reaches 0 → OFF, and sleep_ack_o=1 on the same edge.
- OFF: sleep_req_i=0 → RAMP_UP. Segment 0 is set at the next edge.
- RAMP_UP:
  - Segments are set lowest-first, one every STEP_CYCLES.
  - When seg_cnt_o reaches NUM_SEG → SETTLE.
- SETTLE:
  - Waits for the settle condition (see Optional Feature), then → ON with sleep_ack_o=0.
  - If TIMEOUT_CYCLES elapse first: err_o is set (sticky until rst_i), then → ON with sleep_ack_o=0.
- Request reversal mid-ramp:
  - A reversal in RAMP_DOWN switches to RAMP_UP starting from the current seg_cnt_o.
  - A reversal in RAMP_UP or SETTLE switches to RAMP_DOWN starting from the current seg_cnt_o.
  - The first reversed step occurs at the next edge.
  - sleep_ack_o does not toggle.
- sleep_ack_o changes only on entry to OFF or ON. It never glitches during ramps.
- busy_o=1 exactly in RAMP_DOWN, RAMP_UP and SETTLE.
- NUM_SEG=1: one transition; step spacing is irrelevant.
- Timing with defaults, request change at edge t:
  - Power-down: segment transitions at t+1, t+9, t+17, t+25; ack rises at t+25.
  - Power-up: segments on at the same four edges; ack falls after settle.
- chain_ack_i is treated as asynchronous and passes through a 2-flop synchronizer inside the block.

Optional Feature:
- Macro: PG_SWITCH_CHAIN_ACK_EN.
- Defined: SETTLE exits on the first cycle the synchronized chain_ack_i is 1. TIMEOUT_CYCLES and err_o are active.
- Undefined:
  - chain_ack_i is ignored.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
  - err_o is tied to 0.
  - The synchronizer and timeout counter are not built.

Decomposition:
- Shared package pg_switch_pkg holds:
  - pg_sw_state_e enum with encodings ON=0, RAMP_DOWN=1, OFF=2, RAMP_UP=3, SETTLE=4;
  - default constants PG_SW_NUM_SEG_DEF, PG_SW_STEP_DEF, PG_SW_TIMEOUT_DEF.
- One natural sub-module: pg_switch_step_timer, a reloadable down-counter producing a one-cycle tick every STEP_CYCLES. It is reused for the settle and timeout counts.
- The 2-flop synchronizer is a generic cell instance from the common cells library.

Test Plan:
- Reset with RESET_ON=1, then sleep_req_i=1 at edge 10 → seg_en_o goes 4'b0111@11, 4'b0011@19, 4'b0001@27, 4'b0000@35; sleep_ack_o=1@35; busy_o high over 11..34.
- From OFF, sleep_req_i=0, with chain_ack_i=1 driven 5 cycles after the last segment (macro defined) → seg_en_o reaches 4'b1111; ack falls 2 synchronizer cycles after chain_ack_i; err_o=0.
- Same power-up with chain_ack_i held 0 → err_o=1 exactly TIMEOUT_CYCLES=256 cycles after SETTLE entry; state ON; ack=0; err_o stays 1 through further handshakes.
- Reversal: sleep_req_i=1, then 0 when seg_cnt_o=2 → ramp up resumes from 2, giving 4'b0111 next edge; sleep_ack_o stays 0 throughout.
- rst_i pulsed while seg_cnt_o=1 in RAMP_DOWN, RESET_ON=1 → next edge seg_en_o=4'b1111, ack=0, busy_o=0.
- Macro undefined, SETTLE_CYCLES=16 → ack falls exactly 16 cycles after the fourth segment enables; chain_ack_i toggling has no effect.
